// File: rtl/usr4_pkg.sv
// Shared definitions for the 4-bit universal shift register sequencer:
// command op codes, register mode encodings and sequencer states.
package usr4_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHR  = 3'd2,
        OP_SHL  = 3'd3,
        OP_ROR  = 3'd4,
        OP_ROL  = 3'd5
    } op_e;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Raw op field to command; the two unassigned codes behave as NOP.
    function automatic op_e decode_op(input logic [2:0] raw);
        op_e op;
        case (raw)
            3'd1:    op = OP_LOAD;
            3'd2:    op = OP_SHR;
            3'd3:    op = OP_SHL;
            3'd4:    op = OP_ROR;
            3'd5:    op = OP_ROL;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

    function automatic logic [1:0] op_mode(input op_e op);
        logic [1:0] mode;
        case (op)
            OP_LOAD:         mode = MODE_LOAD;
            OP_SHR, OP_ROR:  mode = MODE_SHR;
            OP_SHL, OP_ROL:  mode = MODE_SHL;
            default:         mode = MODE_HOLD;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/usr4_sequencer_step_counter.sv
// Loadable down-counter that paces the sequencer's RUN state; flags the
// final step so the FSM can leave RUN on the same edge as the last shift.
module step_counter #(
    parameter int COUNT_W = 4
) (
    input  logic               CLK,
    input  logic               Clr_b,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_val,
    input  logic               dec,
    output logic [COUNT_W-1:0] count,
    output logic               last
);

    logic [COUNT_W-1:0] count_r;

    // Count register: load wins over decrement, and it never goes below zero.
    always_ff @(posedge CLK or negedge Clr_b) begin
        if (!Clr_b) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != '0)) begin
            count_r <= count_r - COUNT_W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign last  = (count_r == COUNT_W'(1'b1));

endmodule

// File: rtl/usr4_sequencer.sv
// Command-driven controller for a 4-bit universal shift register: takes one
// command per handshake, steps the register's mode pins, then pulses done.
module usr4_sequencer
    import usr4_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 4
) (
    input  logic               CLK,
    input  logic               Clr_b,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [COUNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0]   cmd_data,
    input  logic               cmd_fill,
    input  logic [WIDTH-1:0]   A_par,
    output logic               s1,
    output logic               s0,
    output logic [WIDTH-1:0]   I_par,
    output logic               MSB_in,
    output logic               LSB_in,
    output logic               busy,
    output logic               done
);

    state_e             state_r;
    op_e                op_r;
    logic               fill_r;
    logic [1:0]         mode_r;
    logic [WIDTH-1:0]   i_par_r;
    logic               done_r;
    logic               ready_r;
    logic               busy_r;

    op_e                op_in_s;
    logic [COUNT_W-1:0] steps_s;
    logic               accept_s;
    logic               cnt_dec_s;
    logic               cnt_last_s;
    logic [COUNT_W-1:0] cnt_val_s;
    logic               msb_s;
    logic               lsb_s;

    // Rotates only feed back the end bits; the middle bits are deliberately unused.
    logic               unused_a_par_s;
    logic [COUNT_W-1:0] unused_cnt_s;

    assign unused_a_par_s = ^A_par[WIDTH-2:1];
    assign unused_cnt_s   = cnt_val_s;

    // Number of register operations the incoming command needs.
    always_comb begin
        op_in_s = decode_op(cmd_op);
        case (op_in_s)
            OP_LOAD:                        steps_s = COUNT_W'(1'b1);
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: steps_s = cmd_count;
            default:                        steps_s = '0;
        endcase
    end

    assign accept_s  = (state_r == IDLE) && cmd_valid;
    assign cnt_dec_s = (state_r == RUN);

    step_counter #(
        .COUNT_W (COUNT_W)
    ) u_step_counter (
        .CLK      (CLK),
        .Clr_b    (Clr_b),
        .load     (accept_s),
        .load_val (steps_s),
        .dec      (cnt_dec_s),
        .count    (cnt_val_s),
        .last     (cnt_last_s)
    );

    // Sequencer FSM with registered mode, parallel data and status outputs.
    always_ff @(posedge CLK or negedge Clr_b) begin
        if (!Clr_b) begin
            state_r <= IDLE;
            op_r    <= OP_NOP;
            fill_r  <= 1'b0;
            mode_r  <= MODE_HOLD;
            i_par_r <= '0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        op_r    <= op_in_s;
                        fill_r  <= cmd_fill;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        if (op_in_s == OP_LOAD) begin
                            i_par_r <= cmd_data;
                        end else begin
                            i_par_r <= i_par_r;
                        end
                        // Zero steps (including NOP) completes without touching the register.
                        if (steps_s == '0) begin
                            state_r <= DONE;
                            mode_r  <= MODE_HOLD;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= RUN;
                            mode_r  <= op_mode(op_in_s);
                            done_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= IDLE;
                        mode_r  <= MODE_HOLD;
                        done_r  <= 1'b0;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt_last_s) begin
                        state_r <= DONE;
                        mode_r  <= MODE_HOLD;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= RUN;
                        mode_r  <= mode_r;
                        done_r  <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    mode_r  <= MODE_HOLD;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    mode_r  <= MODE_HOLD;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Serial inputs; rotates must see the current A_par, so these stay combinational.
    always_comb begin
        msb_s = 1'b0;
        lsb_s = 1'b0;
        if (state_r == RUN) begin
            case (op_r)
                OP_SHR:  msb_s = fill_r;
                OP_SHL:  lsb_s = fill_r;
                OP_ROR:  msb_s = A_par[0];
                OP_ROL:  lsb_s = A_par[WIDTH-1];
                default: begin
                    msb_s = 1'b0;
                    lsb_s = 1'b0;
                end
            endcase
        end else begin
            msb_s = 1'b0;
            lsb_s = 1'b0;
        end
    end

    assign s1        = mode_r[1];
    assign s0        = mode_r[0];
    assign I_par     = i_par_r;
    assign MSB_in    = msb_s;
    assign LSB_in    = lsb_s;
    assign cmd_ready = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_usr4_sequencer.sv
// Bench: sequencer driving a behavioural 4-bit universal shift register,
// table vectors, hand-written corner sequences and random commands.
module tb_usr4_sequencer;

    logic       CLK = 1'b0;
    logic       Clr_b = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_count = 4'd0;
    logic [3:0] cmd_data = 4'd0;
    logic       cmd_fill = 1'b0;
    logic [3:0] A_par;
    logic       s1, s0;
    logic [3:0] I_par;
    logic       MSB_in, LSB_in;
    logic       busy, done;
    logic [3:0] a_reg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    usr4_sequencer dut (
        .CLK       (CLK),
        .Clr_b     (Clr_b),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .cmd_fill  (cmd_fill),
        .A_par     (A_par),
        .s1        (s1),
        .s0        (s0),
        .I_par     (I_par),
        .MSB_in    (MSB_in),
        .LSB_in    (LSB_in),
        .busy      (busy),
        .done      (done)
    );

    // The 4-bit universal shift register controlled by the sequencer.
    always_ff @(posedge CLK or negedge Clr_b) begin
        if (!Clr_b) a_reg <= 4'h0;
        else begin
            case ({s1, s0})
                2'b01:   a_reg <= {MSB_in, a_reg[3:1]};
                2'b10:   a_reg <= {a_reg[2:0], LSB_in};
                2'b11:   a_reg <= I_par;
                default: a_reg <= a_reg;
            endcase
        end
    end
    assign A_par = a_reg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected final register value from the command's arithmetic meaning.
    function automatic logic [3:0] ref_result(input logic [3:0] a, input int op, input int cnt,
                                              input logic [3:0] data, input logic fill);
        int v;
        int r;
        v = int'(a);
        case (op)
            1: return data;
            2: if (cnt >= 4) return fill ? 4'hF : 4'h0;
               else return 4'((v >> cnt) | (fill ? ((15 << (4 - cnt)) & 15) : 0));
            3: if (cnt >= 4) return fill ? 4'hF : 4'h0;
               else return 4'(((v << cnt) & 15) | (fill ? ((1 << cnt) - 1) : 0));
            4: begin r = cnt % 4; return 4'(((v >> r) | (v << (4 - r))) & 15); end
            5: begin r = cnt % 4; return 4'(((v << r) | (v >> (4 - r))) & 15); end
            default: return a;
        endcase
    endfunction

    function automatic int ref_steps(input int op, input int cnt);
        if (op == 1) return 1;
        else if (op >= 2 && op <= 5) return cnt;
        else return 0;
    endfunction

    // Issue one command, measure latency / active cycles, check final state.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [3:0] cnt,
                           input logic [3:0] data, input logic fill, input logic hold_valid,
                           input logic [3:0] exp_a, input int exp_lat);
        int w, lat, act;
        logic got;
        w = 0;
        @(negedge CLK);
        while (!cmd_ready && w < 50) begin
            @(negedge CLK);
            w++;
        end
        check({tag, "_ready_in"}, cmd_ready, 1);
        cmd_op = op; cmd_count = cnt; cmd_data = data; cmd_fill = fill; cmd_valid = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold_valid) cmd_valid = 1'b0;
        lat = 0; act = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge CLK);
            lat++;
            if ({s1, s0} != 2'b00) act++;
            if (hold_valid && !done) check({tag, "_ready_low"}, cmd_ready, 0);
            if (done) got = 1'b1;
        end
        cmd_valid = 1'b0;
        check({tag, "_done_seen"}, got, 1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_active"}, act, exp_lat - 1);
        check({tag, "_A"}, A_par, exp_a);
        check({tag, "_s_final"}, {s1, s0}, 2'b00);
        @(negedge CLK);
        check({tag, "_done_1cyc"}, done, 0);
        check({tag, "_ready_back"}, cmd_ready, 1);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] cnt;
        logic [3:0] data;
        logic       fill;
        logic [3:0] exp_a;
        int         exp_lat;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] shl_exp[4];
    logic [3:0] model_a;
    int         dones;

    initial begin
        vecs.push_back('{3'd1, 4'd0,  4'hA, 1'b0, 4'hA, 2});
        vecs.push_back('{3'd2, 4'd2,  4'h0, 1'b1, 4'hE, 3});
        vecs.push_back('{3'd1, 4'd7,  4'hA, 1'b0, 4'hA, 2});
        vecs.push_back('{3'd3, 4'd3,  4'h0, 1'b0, 4'h0, 4});
        vecs.push_back('{3'd1, 4'd0,  4'hB, 1'b0, 4'hB, 2});
        vecs.push_back('{3'd4, 4'd4,  4'h0, 1'b0, 4'hB, 5});
        vecs.push_back('{3'd1, 4'd0,  4'hA, 1'b0, 4'hA, 2});
        vecs.push_back('{3'd5, 4'd1,  4'h0, 1'b0, 4'h5, 2});
        vecs.push_back('{3'd2, 4'd0,  4'hF, 1'b1, 4'h5, 1});
        vecs.push_back('{3'd7, 4'd5,  4'hF, 1'b1, 4'h5, 1});
        vecs.push_back('{3'd0, 4'd3,  4'hF, 1'b1, 4'h5, 1});
        vecs.push_back('{3'd3, 4'd15, 4'h0, 1'b1, 4'hF, 16});
        vecs.push_back('{3'd1, 4'd0,  4'h6, 1'b0, 4'h6, 2});
        vecs.push_back('{3'd4, 4'd1,  4'h0, 1'b0, 4'h3, 2});

        // Reset state.
        repeat (2) @(negedge CLK);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_s", {s1, s0}, 2'b00);
        check("rst_ipar", I_par, 4'h0);
        check("rst_serial", {MSB_in, LSB_in}, 2'b00);
        check("rst_A", A_par, 4'h0);
        Clr_b = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].cnt, vecs[i].data,
                    vecs[i].fill, 1'b0, vecs[i].exp_a, vecs[i].exp_lat);
        end

        // SHR by 2 with fill 1: cycle-by-cycle view.
        run_cmd("shr_pre", 3'd1, 4'd0, 4'hA, 1'b0, 1'b0, 4'hA, 2);
        @(negedge CLK);
        cmd_op = 3'd2; cmd_count = 4'd2; cmd_fill = 1'b1; cmd_valid = 1'b1;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        @(negedge CLK);
        check("shr_t1_s", {s1, s0}, 2'b01);
        check("shr_t1_A", A_par, 4'hA);
        check("shr_t1_serial", {MSB_in, LSB_in}, 2'b10);
        check("shr_t1_busy", {busy, cmd_ready}, 2'b10);
        @(negedge CLK);
        check("shr_t2_A", A_par, 4'hD);
        check("shr_t2_s", {s1, s0}, 2'b01);
        @(negedge CLK);
        check("shr_t3_A", A_par, 4'hE);
        check("shr_t3_sd", {s1, s0, done}, 3'b001);
        @(negedge CLK);
        check("shr_t4_done", done, 0);

        // SHL by 3 with fill 0: trace A and serial inputs.
        run_cmd("shl_pre", 3'd1, 4'd0, 4'hA, 1'b0, 1'b0, 4'hA, 2);
        shl_exp[0] = 4'hA; shl_exp[1] = 4'h4; shl_exp[2] = 4'h8; shl_exp[3] = 4'h0;
        @(negedge CLK);
        cmd_op = 3'd3; cmd_count = 4'd3; cmd_fill = 1'b0; cmd_valid = 1'b1;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check($sformatf("shl_t%0d_A", i), A_par, shl_exp[i]);
            check($sformatf("shl_t%0d_serial", i), {MSB_in, LSB_in}, 2'b00);
            check($sformatf("shl_t%0d_done", i), done, (i == 3) ? 1 : 0);
        end

        // cmd_valid held through RUN/DONE must not be re-accepted.
        run_cmd("hold_pre", 3'd1, 4'd0, 4'hA, 1'b0, 1'b0, 4'hA, 2);
        run_cmd("hold", 3'd2, 4'd3, 4'h0, 1'b0, 1'b1, 4'h1, 4);

        // Reset in the middle of SHL by 5.
        run_cmd("mid_pre", 3'd1, 4'd0, 4'hA, 1'b0, 1'b0, 4'hA, 2);
        @(negedge CLK);
        cmd_op = 3'd3; cmd_count = 4'd5; cmd_fill = 1'b1; cmd_valid = 1'b1;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("mid_busy_before", busy, 1);
        Clr_b = 1'b0;
        #1;
        check("mid_rst_s", {s1, s0}, 2'b00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_A", A_par, 4'h0);
        check("mid_rst_ready", cmd_ready, 1);
        @(negedge CLK);
        Clr_b = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (done) dones++;
        end
        check("mid_no_done", dones, 0);
        check("mid_A_idle", A_par, 4'h0);
        run_cmd("mid_post", 3'd1, 4'd0, 4'h3, 1'b0, 1'b0, 4'h3, 2);
        model_a = 4'h3;

        // Random commands against the arithmetic reference model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            logic [3:0] cnt, data, exp;
            logic       fill;
            op   = 3'($urandom_range(0, 7));
            cnt  = 4'($urandom_range(0, 15));
            data = 4'($urandom);
            fill = 1'($urandom);
            exp  = ref_result(model_a, int'(op), int'(cnt), data, fill);
            run_cmd($sformatf("rnd%0d_op%0d_n%0d", i, op, cnt), op, cnt, data, fill, 1'b0,
                    exp, ref_steps(int'(op), int'(cnt)) + 1);
            model_a = exp;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
